// File: rtl/spike_train_gen.sv
`default_nettype none
// ============================================================================
//  Module   : spike_train_gen
//  Purpose  : Converts an integer spike count per window into a train of
//             single-cycle spike pulses spread evenly over the window
//             (Bresenham accumulator). Counts arrive on a valid/ready
//             handshake; each window ends with a win_done strobe.
//  Revision : 1.0  initial release
//
//  Optional feature macro: SPIKE_TRAIN_PRELOAD_EN
//    When defined, a 1-entry holding register lets the next request be
//    accepted during a running window and started back-to-back with it.
//
//  Ports
//    clk          in   1      clock
//    reset_sim_n  in   1      asynchronous active-low reset
//    win_len      in   WIN_W  window length L in cycles (sampled on accept)
//    cnt_in       in   CNT_W  requested spikes n for the window
//    cnt_valid    in   1      cnt_in valid
//    cnt_ready    out  1      request can be accepted
//    spike        out  1      registered single-cycle spike pulse
//    win_done     out  1      registered pulse in the last window cycle
//    busy         out  1      window in progress
//    sat_flag     out  1      sticky: some request had n > L (clipped)
//    win_cnt      out  32     completed windows, wrapping
// ============================================================================
module spike_train_gen #(
  parameter int CNT_W = 32,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             reset_sim_n,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             cnt_valid,
  output logic             cnt_ready,
  output logic             spike,
  output logic             win_done,
  output logic             busy,
  output logic             sat_flag,
  output logic [31:0]      win_cnt
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  // Accumulator is one bit wider than the window so acc + n (both < 2L)
  // never overflows.
  logic [WIN_W:0]   r_acc;
  logic [WIN_W-1:0] r_t;
  logic [WIN_W-1:0] r_len;
  logic [WIN_W-1:0] r_n;
  logic             r_spike;
  logic             r_win_done;
  logic             r_sat;
  logic [31:0]      r_win_cnt;

  logic             w_accept;
  logic             w_in_sat;
  logic [WIN_W-1:0] w_in_n;
  logic             w_last;
  logic             w_pre_last;
  logic [WIN_W:0]   w_sum;
  logic             w_start;
  logic [WIN_W-1:0] w_st_len;
  logic [WIN_W-1:0] w_st_n;
  logic             w_st_spike;

  assign w_accept = cnt_valid & cnt_ready;
  assign w_in_sat = (cnt_in > CNT_W'(win_len));
  assign w_in_n   = w_in_sat ? win_len : cnt_in[WIN_W-1:0];

  // r_len >= 1 whenever RUN, so these subtractions only matter in RUN.
  assign w_last     = (r_state == S_RUN) && (r_t == (r_len - WIN_W'(1)));
  assign w_pre_last = (r_t == (r_len - WIN_W'(2)));
  assign w_sum      = r_acc + {1'b0, r_n};

`ifdef SPIKE_TRAIN_PRELOAD_EN
  logic             r_hold_valid;
  logic [WIN_W-1:0] r_hold_len;
  logic [WIN_W-1:0] r_hold_n;
  logic             w_hold_fill;

  assign cnt_ready = (r_state == S_IDLE) | ~r_hold_valid;

  // A request arriving in the last cycle with an empty holding register
  // is started directly instead of being parked first.
  assign w_hold_fill = w_accept && (r_state == S_RUN) && !w_last;
  assign w_start     = (w_accept && (r_state == S_IDLE)) ||
                       (w_last && (r_hold_valid || w_accept));
  assign w_st_len    = r_hold_valid ? r_hold_len : win_len;
  assign w_st_n      = r_hold_valid ? r_hold_n   : w_in_n;

  always_ff @(posedge clk or negedge reset_sim_n) begin
    if (!reset_sim_n) begin
      r_hold_valid <= 1'b0;
      r_hold_len   <= '0;
      r_hold_n     <= '0;
    end else if (w_hold_fill) begin
      r_hold_valid <= 1'b1;
      r_hold_len   <= win_len;
      r_hold_n     <= w_in_n;
    end else if (w_last && r_hold_valid) begin
      r_hold_valid <= 1'b0;
    end
  end
`else
  assign cnt_ready = (r_state == S_IDLE);
  assign w_start   = w_accept;
  assign w_st_len  = win_len;
  assign w_st_n    = w_in_n;
`endif

  // Cycle k=0 of a new window: acc starts at 0, so s = n and the first
  // spike fires only when n == L (n is already clipped to L).
  assign w_st_spike = (w_st_len != '0) && (w_st_n == w_st_len);

  // State register
  always_ff @(posedge clk or negedge reset_sim_n) begin
    if (!reset_sim_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and FSM-decoded outputs
  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state == S_RUN);
    if (w_start) begin
      // A zero-length window never enters RUN.
      w_state_nxt = (w_st_len != '0) ? S_RUN : S_IDLE;
    end else if (w_last) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Datapath: spike/win_done are computed one edge ahead so that they are
  // registered outputs valid during the window cycle they belong to.
  always_ff @(posedge clk or negedge reset_sim_n) begin
    if (!reset_sim_n) begin
      r_acc      <= '0;
      r_t        <= '0;
      r_len      <= '0;
      r_n        <= '0;
      r_spike    <= 1'b0;
      r_win_done <= 1'b0;
      r_sat      <= 1'b0;
      r_win_cnt  <= '0;
    end else begin
      r_win_cnt <= r_win_cnt + {31'b0, r_win_done};

      if (w_accept && w_in_sat) begin
        r_sat <= 1'b1;
      end

      if (w_start) begin
        r_len      <= w_st_len;
        r_n        <= w_st_n;
        r_t        <= '0;
        r_acc      <= w_st_spike ? '0 : {1'b0, w_st_n};
        r_spike    <= w_st_spike;
        r_win_done <= (w_st_len <= WIN_W'(1));
      end else if ((r_state == S_RUN) && !w_last) begin
        r_t        <= r_t + WIN_W'(1);
        r_win_done <= w_pre_last;
        if (w_sum >= {1'b0, r_len}) begin
          r_spike <= 1'b1;
          r_acc   <= w_sum - {1'b0, r_len};
        end else begin
          r_spike <= 1'b0;
          r_acc   <= w_sum;
        end
      end else begin
        r_spike    <= 1'b0;
        r_win_done <= 1'b0;
      end
    end
  end

  assign spike    = r_spike;
  assign win_done = r_win_done;
  assign sat_flag = r_sat;
  assign win_cnt  = r_win_cnt;

endmodule
`default_nettype wire
